// File: rtl/tamagotchi_pkg.sv
// Shared definitions for the Tamagotchi status viewer.
// Modo encodings, default indicator indices and level width.
package tamagotchi_pkg;

  typedef enum logic [1:0] {
    MODO_AUTO   = 2'b00,
    MODO_MANUAL = 2'b01,
    MODO_ALERTA = 2'b10
  } modo_e;

  localparam int IND_ANIMO    = 0;
  localparam int IND_ENERGIA  = 1;
  localparam int IND_DESCANSO = 2;
  localparam int IND_SALUD    = 3;

  localparam int ANCHO_NIVEL_DEF = 2;

endpackage

// File: rtl/tamagotchi_prioridad_critica.sv
// Flags critical indicators and picks the lowest-index one.
// Purely combinational.
module tamagotchi_prioridad_critica
  import tamagotchi_pkg::*;
#(
  parameter int NUM_IND     = 4,
  parameter int ANCHO_NIVEL = ANCHO_NIVEL_DEF,
  parameter int UMBRAL      = 0,
  parameter int IW          = 2
) (
  input  logic [NUM_IND*ANCHO_NIVEL-1:0] Niveles,
  output logic                           any_crit,
  output logic [IW-1:0]                  first_crit
);

  // Thresholds above the level range make every level critical.
  localparam logic [ANCHO_NIVEL-1:0] UMB =
    (UMBRAL >= (2 ** ANCHO_NIVEL)) ? '1 : ANCHO_NIVEL'(UMBRAL);

  always_comb begin
    any_crit   = 1'b0;
    first_crit = '0;
    for (int i = NUM_IND - 1; i >= 0; i--) begin
      if (Niveles[i*ANCHO_NIVEL +: ANCHO_NIVEL] <= UMB) begin
        any_crit   = 1'b1;
        first_crit = IW'(i);
      end
    end
  end

endmodule

// File: rtl/tamagotchi_visor_estados.sv
// Display focus selector: auto rotation, manual stepping
// and pre-emptive lock onto critical indicators.
module tamagotchi_visor_estados
  import tamagotchi_pkg::*;
#(
  parameter int NUM_IND       = 4,
  parameter int ANCHO_NIVEL   = ANCHO_NIVEL_DEF,
  parameter int TIEMPO_CAMBIO = 5,
  parameter int TIEMPO_MANUAL = 10,
  parameter int UMBRAL_ALERTA = 0,
  parameter int IW = (NUM_IND > 1) ? $clog2(NUM_IND) : 1
) (
  input  logic                           clk,
  input  logic                           B_Reset,
  input  logic                           tick_1s,
  input  logic                           B_Test,
  input  logic [NUM_IND*ANCHO_NIVEL-1:0] Niveles,
  output logic [NUM_IND-1:0]             Viendo,
  output logic [IW-1:0]                  Indice,
  output logic [ANCHO_NIVEL-1:0]         Nivel_Visible,
  output logic                           Alerta,
  output logic [1:0]                     Modo
);

  localparam int TMAX =
    (TIEMPO_CAMBIO > TIEMPO_MANUAL) ? TIEMPO_CAMBIO : TIEMPO_MANUAL;
  localparam int CW = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [CW-1:0] FIN_AUTO = CW'(TIEMPO_CAMBIO - 1);
  localparam logic [CW-1:0] FIN_MAN  = CW'(TIEMPO_MANUAL - 1);
  localparam logic [IW-1:0] ULTIMO   = IW'(NUM_IND - 1);

  modo_e           modo_q, modo_n;
  logic [IW-1:0]   idx_q, idx_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [NUM_IND-1:0] viendo_q;
  logic            alerta_q;
  logic            btn_q;
  logic            press;
  logic            any_crit;
  logic [IW-1:0]   first_crit;
  logic [IW-1:0]   idx_sig;
  logic [IW-1:0]   idx_mux;

  tamagotchi_prioridad_critica #(
    .NUM_IND     (NUM_IND),
    .ANCHO_NIVEL (ANCHO_NIVEL),
    .UMBRAL      (UMBRAL_ALERTA),
    .IW          (IW)
  ) u_prio (
    .Niveles    (Niveles),
    .any_crit   (any_crit),
    .first_crit (first_crit)
  );

  assign press   = B_Test & ~btn_q;
  // Explicit wrap so non-power-of-two counts never overflow.
  assign idx_sig = (idx_q == ULTIMO) ? '0 : idx_q + 1'b1;

  always_comb begin
    modo_n = modo_q;
    idx_n  = idx_q;
    cnt_n  = cnt_q;
    unique case (modo_q)
      MODO_AUTO: begin
        if (press) begin
          modo_n = MODO_MANUAL;
          idx_n  = idx_sig;
          cnt_n  = '0;
        end else if (any_crit) begin
          modo_n = MODO_ALERTA;
          idx_n  = first_crit;
          cnt_n  = '0;
        end else if (tick_1s) begin
          if (cnt_q == FIN_AUTO) begin
            cnt_n = '0;
            idx_n = idx_sig;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
      end
      MODO_MANUAL: begin
        if (press) begin
          idx_n = idx_sig;
          cnt_n = '0;
        end else if (tick_1s) begin
          if (cnt_q == FIN_MAN) begin
            modo_n = MODO_AUTO;
            cnt_n  = '0;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
      end
      MODO_ALERTA: begin
        cnt_n = '0;
        if (press) begin
          modo_n = MODO_MANUAL;
          idx_n  = idx_sig;
        end else if (!any_crit) begin
          modo_n = MODO_AUTO;
        end else begin
          idx_n = first_crit;
        end
      end
      default: begin
        modo_n = MODO_AUTO;
        idx_n  = '0;
        cnt_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!B_Reset) begin
      modo_q   <= MODO_AUTO;
      idx_q    <= IW'(IND_ANIMO);
      cnt_q    <= '0;
      viendo_q <= NUM_IND'(1);
      alerta_q <= 1'b0;
      btn_q    <= 1'b0;
    end else begin
      modo_q   <= modo_n;
      idx_q    <= idx_n;
      cnt_q    <= cnt_n;
      viendo_q <= NUM_IND'(1) << idx_n;
      alerta_q <= any_crit;
      btn_q    <= B_Test;
    end
  end

  assign idx_mux       = B_Reset ? idx_q : '0;
  assign Nivel_Visible = Niveles[idx_mux*ANCHO_NIVEL +: ANCHO_NIVEL];
  assign Viendo        = viendo_q;
  assign Indice        = idx_q;
  assign Alerta        = alerta_q;
  assign Modo          = modo_q;

endmodule

// File: tb/tb_tamagotchi_visor_estados.sv
// Directed scoreboard bench for tamagotchi_visor_estados.
// Two instances: 4 indicators and 5 indicators.
module tb_tamagotchi_visor_estados;

  logic       clk = 1'b0;
  logic       B_Reset;
  logic       tick_1s, tick5;
  logic       B_Test, btn5;
  logic [7:0] Niveles;
  logic [9:0] niveles5;
  logic [3:0] Viendo;
  logic [1:0] Indice;
  logic [1:0] Nivel_Visible;
  logic       Alerta;
  logic [1:0] Modo;
  logic [4:0] viendo5;
  logic [2:0] indice5;
  logic [1:0] nivel5;
  logic       alerta5;
  logic [1:0] modo5;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string tag;
    bit    u5;
    int    idx;
    int    modo;
    int    alerta;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  tamagotchi_visor_estados #(
    .NUM_IND(4), .ANCHO_NIVEL(2), .TIEMPO_CAMBIO(3),
    .TIEMPO_MANUAL(10), .UMBRAL_ALERTA(0)
  ) dut (
    .clk(clk), .B_Reset(B_Reset), .tick_1s(tick_1s),
    .B_Test(B_Test), .Niveles(Niveles), .Viendo(Viendo),
    .Indice(Indice), .Nivel_Visible(Nivel_Visible),
    .Alerta(Alerta), .Modo(Modo)
  );

  tamagotchi_visor_estados #(
    .NUM_IND(5), .ANCHO_NIVEL(2), .TIEMPO_CAMBIO(1),
    .TIEMPO_MANUAL(10), .UMBRAL_ALERTA(0)
  ) dut5 (
    .clk(clk), .B_Reset(B_Reset), .tick_1s(tick5),
    .B_Test(btn5), .Niveles(niveles5), .Viendo(viendo5),
    .Indice(indice5), .Nivel_Visible(nivel5),
    .Alerta(alerta5), .Modo(modo5)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(string tag, bit u5, int idx, int modo, int alerta);
    exp_t e;
    e.tag = tag; e.u5 = u5; e.idx = idx;
    e.modo = modo; e.alerta = alerta;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] one;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      one = 32'd1 << e.idx;
      if (e.u5) begin
        chk({e.tag, "_idx"}, 32'(indice5), e.idx);
        chk({e.tag, "_viendo"}, 32'(viendo5), one);
        chk({e.tag, "_modo"}, 32'(modo5), e.modo);
      end else begin
        chk({e.tag, "_idx"}, 32'(Indice), e.idx);
        chk({e.tag, "_viendo"}, 32'(Viendo), one);
        chk({e.tag, "_modo"}, 32'(Modo), e.modo);
        chk({e.tag, "_alerta"}, 32'(Alerta), e.alerta);
      end
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick();
    tick_1s = 1'b1;
    cyc(1);
    tick_1s = 1'b0;
    cyc(3);
  endtask

  initial begin
    B_Reset = 1'b0; tick_1s = 1'b0; tick5 = 1'b0;
    B_Test = 1'b0; btn5 = 1'b0;
    Niveles = 8'hFE; niveles5 = 10'h3FF;

    // Reset state; level mux shows indicator 0 during reset
    push("reset", 0, 0, 0, 0);
    push("reset5", 1, 0, 0, 0);
    cyc(2);
    drain();
    chk("reset_nivel", 32'(Nivel_Visible), 32'd2);
    Niveles = 8'hFF;
    B_Reset = 1'b1;
    cyc(1);

    // Auto rotation every third tick
    for (int t = 1; t <= 15; t++) begin
      push($sformatf("auto_t%0d", t), 0, (t / 3) % 4, 0, 0);
      tick();
      drain();
    end

    // Held button gives one advance
    push("hold_first", 0, 2, 1, 0);
    B_Test = 1'b1;
    cyc(1);
    drain();
    push("hold_end", 0, 2, 1, 0);
    cyc(19);
    drain();
    B_Test = 1'b0;
    cyc(1);
    for (int t = 1; t <= 9; t++) tick();
    push("manual_9", 0, 2, 1, 0);
    drain();
    push("manual_10", 0, 2, 0, 0);
    tick();
    drain();

    // Advance to indicator 0, then make Descanso critical
    for (int t = 1; t <= 6; t++) tick();
    push("auto_idx0", 0, 0, 0, 0);
    drain();
    Niveles = 8'hCF;
    #1;
    chk("nivel_pre", 32'(Nivel_Visible), 32'd3);
    push("crit2", 0, 2, 2, 1);
    cyc(1);
    drain();
    chk("crit2_nivel", 32'(Nivel_Visible), 32'd0);
    Niveles = 8'hEF;
    #1;
    chk("restore_nivel", 32'(Nivel_Visible), 32'd2);
    push("restore", 0, 2, 0, 0);
    cyc(1);
    drain();

    // Two criticals: lowest wins, then the remaining one
    Niveles = 8'h33;
    push("crit13", 0, 1, 2, 1);
    cyc(1);
    drain();
    Niveles = 8'h3F;
    push("crit3", 0, 3, 2, 1);
    cyc(1);
    drain();

    // Press coinciding with tick expiry at indicator 3
    Niveles = 8'hFF;
    push("clear3", 0, 3, 0, 0);
    cyc(1);
    drain();
    tick();
    tick();
    push("press_tick", 0, 0, 1, 0);
    tick_1s = 1'b1;
    B_Test = 1'b1;
    cyc(1);
    drain();
    tick_1s = 1'b0;
    cyc(3);
    B_Test = 1'b0;
    cyc(1);
    for (int t = 1; t <= 9; t++) tick();
    push("pt_man9", 0, 0, 1, 0);
    drain();
    push("pt_man10", 0, 0, 0, 0);
    tick();
    drain();

    // Reset in the middle of manual mode
    B_Test = 1'b1;
    push("man_again", 0, 1, 1, 0);
    cyc(1);
    drain();
    B_Test = 1'b0;
    cyc(1);
    B_Reset = 1'b0;
    tick_1s = 1'b1;
    B_Test = 1'b1;
    push("mid_reset", 0, 0, 0, 0);
    cyc(1);
    drain();
    B_Reset = 1'b1;
    tick_1s = 1'b0;
    B_Test = 1'b0;
    push("post_reset", 0, 0, 0, 0);
    cyc(1);
    drain();

    // Five indicators, one tick per step
    for (int t = 1; t <= 12; t++) begin
      push($sformatf("n5_t%0d", t), 1, t % 5, 0, 0);
      tick5 = 1'b1;
      cyc(1);
      tick5 = 1'b0;
      chk("n5_range", 32'(indice5 < 3'd5), 32'd1);
      cyc(1);
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tamagotchi_visor_estados.md
Name: tamagotchi_visor_estados

Overview:
Parametrised successor to the Tamagotchi mode/view selector. Cycles the display focus across NUM_IND status indicators (default: Animo, Energia, Descanso, Salud).
- Auto-rotates on a 1 s tick.
- Supports manual stepping via B_Test.
- Pre-empts rotation to lock onto a critical indicator.
Sits between the level registers (need counters) and the display/sprite driver.

Parameters:
NUM_IND, 4, number of indicators viewed (>=2)
ANCHO_NIVEL, 2, width of each indicator level
TIEMPO_CAMBIO, 5, ticks each indicator stays shown in auto mode (>=1)
TIEMPO_MANUAL, 10, ticks without a B_Test press before manual mode returns to auto (>=1)
UMBRAL_ALERTA, 0, level <= this value is critical

Ports:
clk  in  1  system clock
B_Reset  in  1  synchronous reset, active-low
tick_1s  in  1  one-cycle enable pulse, once per second
B_Test  in  1  debounced button level, 1 = pressed
Niveles  in  NUM_IND*ANCHO_NIVEL  packed levels; indicator i occupies bits [i*ANCHO_NIVEL +: ANCHO_NIVEL]
Viendo  out  NUM_IND  one-hot of the indicator shown
Indice  out  clog2(NUM_IND)  binary index of the indicator shown
Nivel_Visible  out  ANCHO_NIVEL  level of the shown indicator
Alerta  out  1  any indicator critical
Modo  out  2  00 AUTO, 01 MANUAL, 10 ALERTA

Behaviour:
Reset
- Sampled on the rising clk edge while B_Reset=0.
- Reset values: Indice=0, Viendo=one-hot bit 0, Modo=AUTO, Alerta=0, tick counter=0, B_Test edge register=0.
- Reset overrides every other event. Reset mid-rotation or mid-manual returns immediately to AUTO on indicator 0.

Outputs
- Indice, Viendo, Modo and Alerta are registered.
- Viendo always equals 1<<Indice.
- Nivel_Visible is a combinational mux of Niveles at the registered Indice. Zero latency from a level change; during reset it shows indicator 0's level.

Press detection
- press = B_Test & ~B_Test_q. One register; rising edge only. Holding the button gives one press.

Critical detection
- crit[i] = (level i <= UMBRAL_ALERTA).
- Alerta is registered OR(crit): 1-cycle latency.
- first_crit = lowest index with crit set.

States
- AUTO:
  - On a tick_1s cycle, the counter increments. When the counter == TIEMPO_CAMBIO-1 on a tick, it clears to 0 and Indice advances.
  - Wrap-around: NUM_IND-1 -> 0.
  - press: go to MANUAL, Indice+1 (with wrap), counter=0.
  - else if any crit: go to ALERTA, Indice=first_crit, counter=0.
- MANUAL:
  - press: Indice+1 (with wrap), counter=0.
  - On a tick with no press, the counter increments. At TIEMPO_MANUAL-1 it returns to AUTO with counter=0; Indice is kept.
  - crit does not pre-empt MANUAL. The user owns the display.
- ALERTA:
  - Indice tracks first_crit each cycle.
  - When no crit remains: go to AUTO, counter=0, Indice kept.
  - press: go to MANUAL, Indice+1 (with wrap).

Simultaneous events and priority (per cycle)
- Priority order: reset > press > crit > tick.
- Tick expiry in the same cycle as a press: the press wins. Exactly one advance; counter=0.

Counter
- Width clog2(max(TIEMPO_CAMBIO, TIEMPO_MANUAL)).
- Never exceeds its terminal value.
- tick_1s is ignored while B_Reset=0.

Indice arithmetic
- Explicit compare-and-wrap; no reliance on power-of-two overflow.
- NUM_IND non-power-of-two (e.g. 3 or 5) must wrap correctly.

Decomposition:
Shared package (tamagotchi_pkg)
- Modo encodings MODO_AUTO/MODO_MANUAL/MODO_ALERTA.
- Default indicator indices IND_ANIMO=0, IND_ENERGIA=1, IND_DESCANSO=2, IND_SALUD=3.
- Default ANCHO_NIVEL.
Sub-module
- tamagotchi_prioridad_critica: combinational; Niveles + UMBRAL -> any_crit, first_crit index.
- Everything else stays in the top module.

Test Plan:
1. Reset, then release; NUM_IND=4, TIEMPO_CAMBIO=3, all levels=3, tick every 4 cycles -> Indice 0,1,2,3,0 advancing on every 3rd tick. Viendo 0001->0010->0100->1000->0001. Modo=00.
2. B_Test held high for 20 cycles while in AUTO at Indice=1 -> single advance to 2. Modo=01. After release and TIEMPO_MANUAL=10 ticks with no press -> Modo=00, Indice=2.
3. Set Niveles so indicator 2 (Descanso)=0 while others=3, in AUTO at Indice=0 -> next cycle Modo=10, Indice=2, Nivel_Visible=0, Alerta=1 one cycle after the level change. Restore to 2 -> Modo=00, Alerta=0.
4. Indicators 1 and 3 critical together -> Indice=1. Clear indicator 1 only -> Indice=3, Modo stays 10.
5. Press and tick expiry in the same cycle at Indice=3 -> Indice=0 (one advance), counter=0. B_Reset=0 for one cycle mid-MANUAL -> Indice=0, Modo=00 on the next edge.
6. NUM_IND=5, TIEMPO_CAMBIO=1 -> Indice wraps 4->0 and never reaches 5-7. Viendo stays one-hot throughout.
